// File: rtl/udp_tx_arb_pkg.sv
// udp_tx_arb_pkg: shared constants for the UDP TX arbiter.
//   - FSM state encoding (2-bit)
//   - payload byte, IP and port field widths
//   - default payload stall limit used when UDP_TX_ARB_TIMEOUT_EN is defined
package udp_tx_arb_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned IP_W            = 32;
    localparam int unsigned PORT_W          = 16;
    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HDR     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_ABORT   = 2'd3;

endpackage

// File: rtl/udp_tx_arbiter_rr_priority_select.sv
// rr_priority_select: combinational round-robin picker.
// Searches i_req starting one above i_last, wrapping at N, and returns the
// first set request.
//   i_req      : request vector
//   i_last     : index of the previous winner
//   o_onehot_c : one-hot winner (all zeros when no request)
//   o_idx_c    : winner index (0 when no request)
module rr_priority_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_onehot_c,
    output logic [IDX_W-1:0] o_idx_c
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Scan offsets 1..N from the last winner; the first hit wins.
    always_comb begin
        o_onehot_c = '0;
        o_idx_c    = '0;
        found      = 1'b0;
        sum        = '0;
        cand       = '0;
        for (int unsigned off = 1; off <= N; off++) begin
            sum  = {1'b0, i_last} + (IDX_W+1)'(off);
            cand = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N)) : IDX_W'(sum);
            if (!found && i_req[cand]) begin
                found            = 1'b1;
                o_onehot_c[cand] = 1'b1;
                o_idx_c          = cand;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin share of the UDP TX header/payload port between
// REQ_NUM byte-stream requesters. A grant covers a whole packet: header
// handshake with the destination latched at grant, then payload passthrough
// until the tlast beat is accepted.
// Optional macro UDP_TX_ARB_TIMEOUT_EN: a payload stall of TIMEOUT_CYCLES
// cycles terminates the packet with a single 0x00 beat carrying tlast and
// tuser (abort).
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_src_*                          per-requester AXI-S bytes + destination
//   o_src_tready                     per-requester ready
//   o_tx_udp_hdr_* / i_tx_udp_hdr_*  header handshake and latched fields
//   o_tx_udp_payload_axis_*          payload stream to the UDP stack
//   o_grant, o_busy                  status
module udp_tx_arbiter
    import udp_tx_arb_pkg::*;
#(
    parameter int unsigned REQ_NUM        = 4,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [REQ_NUM*BYTE_W-1:0] i_src_tdata,
    input  logic [REQ_NUM-1:0]        i_src_tvalid,
    input  logic [REQ_NUM-1:0]        i_src_tlast,
    output logic [REQ_NUM-1:0]        o_src_tready,
    input  logic [REQ_NUM*IP_W-1:0]   i_src_dest_ip,
    input  logic [REQ_NUM*PORT_W-1:0] i_src_dest_port,
    output logic                      o_tx_udp_hdr_valid,
    input  logic                      i_tx_udp_hdr_ready,
    output logic [IP_W-1:0]           o_tx_udp_dest_ip,
    output logic [PORT_W-1:0]         o_tx_udp_dest_port,
    output logic [BYTE_W-1:0]         o_tx_udp_payload_axis_tdata,
    output logic                      o_tx_udp_payload_axis_tvalid,
    output logic                      o_tx_udp_payload_axis_tlast,
    output logic                      o_tx_udp_payload_axis_tuser,
    input  logic                      i_tx_udp_payload_axis_tready,
    output logic [REQ_NUM-1:0]        o_grant,
    output logic                      o_busy
);

    localparam int unsigned IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    // Elaboration-time range check on the configuration.
    if (REQ_NUM < 2 || REQ_NUM > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("udp_tx_arbiter: REQ_NUM must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    logic [1:0]         r_state, n_state;
    logic [REQ_NUM-1:0] r_grant, n_grant;
    logic [IDX_W-1:0]   r_gidx, n_gidx;
    logic [IDX_W-1:0]   r_last, n_last;
    logic               r_hdr_valid, n_hdr_valid;
    logic [IP_W-1:0]    r_ip, n_ip;
    logic [PORT_W-1:0]  r_port, n_port;
    logic               r_busy;

    logic [BYTE_W-1:0]  src_data [REQ_NUM];
    logic [IP_W-1:0]    src_ip   [REQ_NUM];
    logic [PORT_W-1:0]  src_port [REQ_NUM];

    logic [REQ_NUM-1:0] win_onehot_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic               g_valid_c;
    logic               g_last_c;
    logic               pay_fire_c;

`ifdef UDP_TX_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] r_cnt, n_cnt;
`endif

    // Unpack the flat requester buses.
    always_comb begin
        for (int k = 0; k < REQ_NUM; k++) begin
            src_data[k] = i_src_tdata[k*BYTE_W +: BYTE_W];
            src_ip[k]   = i_src_dest_ip[k*IP_W +: IP_W];
            src_port[k] = i_src_dest_port[k*PORT_W +: PORT_W];
        end
    end

    rr_priority_select #(
        .N     (REQ_NUM),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req      (i_src_tvalid),
        .i_last     (r_last),
        .o_onehot_c (win_onehot_c),
        .o_idx_c    (win_idx_c)
    );

    assign g_valid_c  = i_src_tvalid[r_gidx];
    assign g_last_c   = i_src_tlast[r_gidx];
    assign pay_fire_c = (r_state == S_PAYLOAD) && g_valid_c && i_tx_udp_payload_axis_tready;

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_last      <= IDX_W'(REQ_NUM - 1);
            r_hdr_valid <= 1'b0;
            r_ip        <= '0;
            r_port      <= '0;
            r_busy      <= 1'b0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_state     <= n_state;
            r_grant     <= n_grant;
            r_gidx      <= n_gidx;
            r_last      <= n_last;
            r_hdr_valid <= n_hdr_valid;
            r_ip        <= n_ip;
            r_port      <= n_port;
            r_busy      <= (n_state == S_HDR) || (n_state == S_PAYLOAD);
`ifdef UDP_TX_ARB_TIMEOUT_EN
            r_cnt       <= n_cnt;
`endif
        end
    end

    // Next-state and next registered-output logic.
    always_comb begin
        n_state     = r_state;
        n_grant     = r_grant;
        n_gidx      = r_gidx;
        n_last      = r_last;
        n_hdr_valid = r_hdr_valid;
        n_ip        = r_ip;
        n_port      = r_port;
`ifdef UDP_TX_ARB_TIMEOUT_EN
        n_cnt       = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (|i_src_tvalid) begin
                    n_state     = S_HDR;
                    n_grant     = win_onehot_c;
                    n_gidx      = win_idx_c;
                    n_last      = win_idx_c;
                    n_hdr_valid = 1'b1;
                    n_ip        = src_ip[win_idx_c];
                    n_port      = src_port[win_idx_c];
                end
            end
            S_HDR: begin
                if (i_tx_udp_hdr_ready) begin
                    n_hdr_valid = 1'b0;
                    n_state     = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (pay_fire_c && g_last_c) begin
                    n_state = S_IDLE;
                    n_grant = '0;
                end
`ifdef UDP_TX_ARB_TIMEOUT_EN
                // Stall counter: only cycles with the granted tvalid low count.
                if (pay_fire_c) begin
                    n_cnt = '0;
                end else if (!g_valid_c) begin
                    if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        n_state = S_ABORT;
                        n_cnt   = '0;
                    end else begin
                        n_cnt = r_cnt + CNT_W'(1);
                    end
                end
`endif
            end
`ifdef UDP_TX_ARB_TIMEOUT_EN
            S_ABORT: begin
                if (i_tx_udp_payload_axis_tready) begin
                    n_state = S_IDLE;
                    n_grant = '0;
                end
            end
`else
            S_ABORT: n_state = S_IDLE;
`endif
            default: n_state = S_IDLE;
        endcase
    end

    // Payload passthrough from the granted requester (abort beat when enabled).
    always_comb begin
        o_tx_udp_payload_axis_tdata  = '0;
        o_tx_udp_payload_axis_tvalid = 1'b0;
        o_tx_udp_payload_axis_tlast  = 1'b0;
        o_tx_udp_payload_axis_tuser  = 1'b0;
        o_src_tready                 = '0;
        if (r_state == S_PAYLOAD) begin
            o_tx_udp_payload_axis_tdata  = src_data[r_gidx];
            o_tx_udp_payload_axis_tvalid = g_valid_c;
            o_tx_udp_payload_axis_tlast  = g_last_c;
            o_src_tready                 = r_grant & {REQ_NUM{i_tx_udp_payload_axis_tready}};
        end
`ifdef UDP_TX_ARB_TIMEOUT_EN
        if (r_state == S_ABORT) begin
            o_tx_udp_payload_axis_tvalid = 1'b1;
            o_tx_udp_payload_axis_tlast  = 1'b1;
            o_tx_udp_payload_axis_tuser  = 1'b1;
        end
`endif
    end

    assign o_grant            = r_grant;
    assign o_tx_udp_hdr_valid = r_hdr_valid;
    assign o_tx_udp_dest_ip   = r_ip;
    assign o_tx_udp_dest_port = r_port;
    assign o_busy             = r_busy;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed self-checking bench for udp_tx_arbiter.
// Per-requester byte queues act as sources; accepted payload beats and header
// handshakes are logged at the falling edge and checked against hand-derived
// values.
module tb_udp_tx_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [N*8-1:0]  src_tdata;
    logic [N-1:0]    src_tvalid;
    logic [N-1:0]    src_tlast;
    logic [N-1:0]    src_tready;
    logic [N*32-1:0] src_dest_ip;
    logic [N*16-1:0] src_dest_port;
    logic          hdr_valid;
    logic          hdr_ready;
    logic [31:0]   dest_ip;
    logic [15:0]   dest_port;
    logic [7:0]    p_tdata;
    logic          p_tvalid;
    logic          p_tlast;
    logic          p_tuser;
    logic          p_tready;
    logic [N-1:0]  grant;
    logic          busy;

    always #5 clk = ~clk;

    udp_tx_arbiter #(
        .REQ_NUM        (N),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_clk                        (clk),
        .i_rst                        (i_rst),
        .i_src_tdata                  (src_tdata),
        .i_src_tvalid                 (src_tvalid),
        .i_src_tlast                  (src_tlast),
        .o_src_tready                 (src_tready),
        .i_src_dest_ip                (src_dest_ip),
        .i_src_dest_port              (src_dest_port),
        .o_tx_udp_hdr_valid           (hdr_valid),
        .i_tx_udp_hdr_ready           (hdr_ready),
        .o_tx_udp_dest_ip             (dest_ip),
        .o_tx_udp_dest_port           (dest_port),
        .o_tx_udp_payload_axis_tdata  (p_tdata),
        .o_tx_udp_payload_axis_tvalid (p_tvalid),
        .o_tx_udp_payload_axis_tlast  (p_tlast),
        .o_tx_udp_payload_axis_tuser  (p_tuser),
        .i_tx_udp_payload_axis_tready (p_tready),
        .o_grant                      (grant),
        .o_busy                       (busy)
    );

    // Source queues
    logic [7:0]  mem   [N][16];
    bit          mlast [N][16];
    int          rd [N];
    int          wr [N];
    int          hold_idx [N];
    logic [31:0] ip_r [N];
    logic [15:0] port_r [N];

    // Logs
    logic [7:0]  out_data [64];
    bit          out_last [64];
    bit          out_user [64];
    int          out_cyc  [64];
    int          n_out;
    int          hdr_src [16];
    int          hdr_cyc [16];
    logic [31:0] hdr_ip  [16];
    int          n_hdr;
    int          hv_cnt;
    int          cyc;
    bit          toggle;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic push(input int k, input logic [7:0] d, input bit l);
        mem[k][wr[k]]   = d;
        mlast[k][wr[k]] = l;
        wr[k]++;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            logic v;
            v = (rd[k] != wr[k]) && (hold_idx[k] != rd[k]);
            src_tvalid[k]            = v;
            src_tdata[k*8 +: 8]      = v ? mem[k][rd[k]] : 8'h00;
            src_tlast[k]             = v ? mlast[k][rd[k]] : 1'b0;
            src_dest_ip[k*32 +: 32]  = ip_r[k];
            src_dest_port[k*16 +: 16] = port_r[k];
        end
    endtask

    task automatic clear_logs();
        n_out = 0; n_hdr = 0; hv_cnt = 0;
        for (int k = 0; k < N; k++) begin
            rd[k] = 0; wr[k] = 0; hold_idx[k] = -1;
        end
    endtask

    // One clock: log at the falling edge, then update sources after the rising edge.
    task automatic step();
        bit pop [N];
        @(negedge clk);
        cyc++;
        if (hdr_valid) hv_cnt++;
        if (hdr_valid && hdr_ready && n_hdr < 16) begin
            hdr_src[n_hdr] = oh2i(grant);
            hdr_ip[n_hdr]  = dest_ip;
            hdr_cyc[n_hdr] = cyc;
            n_hdr++;
        end
        if (p_tvalid && p_tready && n_out < 64) begin
            out_data[n_out] = p_tdata;
            out_last[n_out] = p_tlast;
            out_user[n_out] = p_tuser;
            out_cyc[n_out]  = cyc;
            n_out++;
        end
        for (int k = 0; k < N; k++) pop[k] = src_tready[k] && src_tvalid[k];
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (pop[k]) rd[k]++;
        if (toggle) p_tready = ~p_tready;
        drive();
        #1;
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (rd[k] != wr[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int i = 0;
        while (!(all_empty() && !busy && grant == '0) && i < budget) begin
            step();
            i++;
        end
        chk(tag, 64'(i < budget), 64'd1);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        clear_logs();
        drive();
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp2 [10];
        logic [7:0] exp_b;
        int lim;
        cyc = 0; toggle = 0;
        p_tready = 1'b1; hdr_ready = 1'b1;
        for (int k = 0; k < N; k++) begin ip_r[k] = '0; port_r[k] = '0; end
        clear_logs();
        drive();
        do_reset();

        // Reset state
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_hdr_valid", 64'(hdr_valid), 64'h0);
        chk("rst_ip", 64'(dest_ip), 64'h0);
        chk("rst_port", 64'(dest_port), 64'h0);
        chk("rst_tvalid", 64'(p_tvalid), 64'h0);
        chk("rst_src_tready", 64'(src_tready), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);

        // T1: single 3-byte packet from requester 0
        ip_r[0] = 32'hC0A80180; port_r[0] = 16'h04D2;
        push(0, 8'hAA, 0); push(0, 8'hBB, 0); push(0, 8'hCC, 1);
        drive(); #1;
        step();
        chk("t1_grant", 64'(grant), 64'h1);
        chk("t1_hdr_valid", 64'(hdr_valid), 64'h1);
        chk("t1_ip", 64'(dest_ip), 64'hC0A80180);
        chk("t1_port", 64'(dest_port), 64'h04D2);
        chk("t1_busy", 64'(busy), 64'h1);
        chk("t1_src_tready_hdr", 64'(src_tready), 64'h0);
        step();
        chk("t1_hdr_cleared", 64'(hdr_valid), 64'h0);
        chk("t1_first_byte", 64'(p_tdata), 64'hAA);
        chk("t1_src_tready", 64'(src_tready), 64'h1);
        chk("t1_tuser", 64'(p_tuser), 64'h0);
        wait_idle("t1_idle", 20);
        chk("t1_hv_cycles", 64'(hv_cnt), 64'd1);
        chk("t1_nbytes", 64'(n_out), 64'd3);
        chk("t1_bytes", {40'h0, out_data[0], out_data[1], out_data[2]}, 64'hAABBCC);
        chk("t1_lasts", {61'h0, out_last[0], out_last[1], out_last[2]}, 64'b001);
        chk("t1_grant_end", 64'(grant), 64'h0);

        // T2: all four requesting, round-robin rotation
        do_reset();
        for (int k = 0; k < N; k++) begin
            ip_r[k]   = 32'h0A000000 + 32'(k);
            port_r[k] = 16'h03E8 + 16'(k);
            push(k, 8'((k << 4)), 0);
            push(k, 8'((k << 4) | 1), 1);
        end
        push(0, 8'h02, 0); push(0, 8'h03, 1);
        drive(); #1;
        wait_idle("t2_idle", 100);
        exp2 = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
        chk("t2_nhdr", 64'(n_hdr), 64'd5);
        chk("t2_nbytes", 64'(n_out), 64'd10);
        chk("t2_order", {44'h0, 4'(hdr_src[0]), 4'(hdr_src[1]), 4'(hdr_src[2]),
                         4'(hdr_src[3]), 4'(hdr_src[4])}, 64'h01230);
        chk("t2_ip1", 64'(hdr_ip[1]), 64'h0A000001);
        for (int i = 0; i < 10; i++) chk($sformatf("t2_byte%0d", i), 64'(out_data[i]), 64'(exp2[i]));
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_gap%0d", i), 64'(hdr_cyc[i+1] - out_cyc[2*i+1]), 64'd2);

        // T3: header back-pressure on requester 2, fields latched at grant
        clear_logs();
        ip_r[2] = 32'hC0A80005; port_r[2] = 16'h1F90;
        push(2, 8'h5A, 0); push(2, 8'h5B, 1);
        hdr_ready = 1'b0;
        drive(); #1;
        step();
        chk("t3_grant", 64'(grant), 64'h4);
        ip_r[2] = 32'hDEADBEEF; port_r[2] = 16'h0000;
        drive(); #1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t3_hv%0d", i), 64'(hdr_valid), 64'h1);
            chk($sformatf("t3_ip%0d", i), {dest_ip, 16'h0, dest_port}, 64'hC0A80005_00001F90);
            chk($sformatf("t3_rdy%0d", i), 64'(src_tready), 64'h0);
        end
        hdr_ready = 1'b1;
        step();
        wait_idle("t3_idle", 20);
        chk("t3_hv_cycles", 64'(hv_cnt), 64'd6);
        chk("t3_hdr_ip", 64'(hdr_ip[0]), 64'hC0A80005);
        chk("t3_bytes", {48'h0, out_data[0], out_data[1]}, 64'h5A5B);

        // T4: tready toggling during a 4-byte packet from requester 1
        clear_logs();
        push(1, 8'h01, 0); push(1, 8'h02, 0); push(1, 8'h03, 0); push(1, 8'h04, 1);
        toggle = 1'b1;
        drive(); #1;
        lim = 0;
        while (!(all_empty() && !busy) && lim < 40) begin
            step();
            lim++;
            if (busy && !hdr_valid)
                chk("t4_rdy_mirror", 64'(src_tready), {60'h0, 2'b00, p_tready, 1'b0});
        end
        chk("t4_done", 64'(lim < 40), 64'd1);
        toggle = 1'b0; p_tready = 1'b1;
        chk("t4_nbytes", 64'(n_out), 64'd4);
        chk("t4_bytes", {32'h0, out_data[0], out_data[1], out_data[2], out_data[3]}, 64'h01020304);
        chk("t4_last", {60'h0, out_last[0], out_last[1], out_last[2], out_last[3]}, 64'b0001);

        // T5: reset mid-packet, then requester 0 wins over 3
        clear_logs();
        push(2, 8'h71, 0); push(2, 8'h72, 0); push(2, 8'h73, 0); push(2, 8'h74, 1);
        drive(); #1;
        lim = 0;
        while (n_out < 1 && lim < 20) begin step(); lim++; end
        chk("t5_reach_byte2", 64'(lim < 20), 64'd1);
        i_rst = 1'b1;
        step();
        chk("t5_rst_out", {56'h0, grant, hdr_valid, p_tvalid, p_tlast, p_tuser},
            64'h0);
        chk("t5_rst_rdy", {59'h0, src_tready, busy}, 64'h0);
        i_rst = 1'b0;
        clear_logs();
        push(3, 8'h91, 1);
        push(0, 8'h81, 0); push(0, 8'h82, 1);
        drive(); #1;
        wait_idle("t5_idle", 50);
        chk("t5_first_src", 64'(hdr_src[0]), 64'd0);
        chk("t5_second_src", 64'(hdr_src[1]), 64'd3);
        chk("t5_bytes", {40'h0, out_data[0], out_data[1], out_data[2]}, 64'h818291);
        chk("t5_lasts", {61'h0, out_last[0], out_last[1], out_last[2]}, 64'b011);

`ifdef UDP_TX_ARB_TIMEOUT_EN
        // T6: requester 1 stalls after one byte; abort after 8 stall cycles
        clear_logs();
        push(1, 8'hE1, 0); push(1, 8'hE2, 1);
        hold_idx[1] = 1;
        drive(); #1;
        lim = 0;
        while (n_out < 2 && lim < 40) begin step(); lim++; end
        chk("t6_abort_seen", 64'(lim < 40), 64'd1);
        exp_b = 8'h00;
        chk("t6_byte0", 64'(out_data[0]), 64'hE1);
        chk("t6_abort_data", 64'(out_data[1]), 64'(exp_b));
        chk("t6_abort_flags", {61'h0, out_last[1], out_user[1], out_user[0]}, 64'b110);
        chk("t6_stall_len", 64'(out_cyc[1] - out_cyc[0]), 64'd9);
        chk("t6_grant_clear", {59'h0, grant, busy}, 64'h0);
        hold_idx[1] = -1;
        drive(); #1;
        wait_idle("t6_idle", 30);
        chk("t6_rest", {55'h0, out_data[2], out_last[2]}, {55'h0, 8'hE2, 1'b1});
        chk("t6_nhdr", 64'(n_hdr), 64'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
